serial_frame_rx: RTL
====================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter WIDTH SHALL default to 4 and set the number of data bits per frame and the width of parallel_out.
REQ-002 Parameter MSB_FIRST SHALL default to 1; 1 = first data bit received lands in parallel_out[WIDTH-1], 0 = first data bit lands in parallel_out[0].
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-004 Port reset SHALL be an input, 1 bit, synchronous active-high reset.
REQ-005 Port serial_in SHALL be an input, 1 bit, the serial line: idle high, one bit per clk cycle, same clock domain as the transmitting shift register.
REQ-006 Port parallel_out SHALL be an output, WIDTH bits, the last correctly framed data word.
REQ-007 Port valid SHALL be an output, 1 bit, a one-cycle pulse marking a new word on parallel_out.
REQ-008 Port frame_err SHALL be an output, 1 bit, a one-cycle pulse marking a bad stop bit.
REQ-009 Port busy SHALL be an output, 1 bit, high while a frame is being received (states DATA and STOP).

Function
REQ-010 Frame format SHALL be: start bit 0, then WIDTH data bits, then stop bit 1, each lasting exactly one clk cycle, with no oversampling.
REQ-011 The FSM SHALL have the states IDLE, DATA, STOP and WAIT_IDLE.
REQ-012 In IDLE, serial_in=0 sampled at an edge SHALL be taken as the start bit and move the FSM to DATA with the bit counter cleared.
REQ-013 In IDLE, serial_in=1 SHALL keep the FSM in IDLE.
REQ-014 In DATA, each edge SHALL shift serial_in into an internal shift register (direction set by MSB_FIRST) and increment the counter.
REQ-015 After the WIDTH-th data bit the FSM SHALL move to STOP.
REQ-016 In STOP, serial_in=1 SHALL load parallel_out from the shift register, assert valid for the next cycle only, and move the FSM to IDLE.
REQ-017 In STOP, serial_in=0 SHALL leave parallel_out unchanged, assert frame_err for the next cycle only, and move the FSM to WAIT_IDLE.
REQ-018 In WAIT_IDLE the FSM SHALL stay until serial_in=1 is sampled, then move to IDLE; a 0 in this state is never taken as a start bit.
REQ-019 Latency: with the start bit sampled at edge 0, valid or frame_err SHALL be high in the cycle after edge WIDTH+1.
REQ-020 Back-to-back frames: a start bit in the cycle immediately after a good stop bit SHALL be accepted, with valid of the old frame and the new frame's DATA entry overlapping.
REQ-021 parallel_out SHALL hold its value across idle periods, errors and partial frames; only a good stop bit updates it.
REQ-022 valid and frame_err SHALL never be high in the same cycle.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap inside a frame.

Reset
REQ-024 While reset=1 at an edge, the FSM SHALL go to IDLE, and the counter, shift register and parallel_out SHALL clear to 0.
REQ-025 While reset=1, valid, frame_err and busy SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no valid and no frame_err; reception restarts at the next start bit after reset falls.
REQ-027 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-028 The FSM state encoding (2-bit localparams IDLE=0, DATA=1, STOP=2, WAIT_IDLE=3) SHALL live in the shared package serial_pkg, which the matching transmitter also uses.
REQ-029 The data shifter SHALL be a sub-module, sipo_shift (WIDTH, MSB_FIRST, clk, reset, shift_en, din, q); FSM, counter and output registers stay in serial_frame_rx.

Verification
REQ-030 Reset release then serial_in 0,1,1,0,0,1 (MSB_FIRST=1) -> parallel_out=4'b1100 and valid=1 for exactly one cycle, 6 cycles after the start edge.
REQ-031 Frame 0,1,0,1,0 followed by a bad stop bit 0 -> frame_err one-cycle pulse, parallel_out keeps its previous value, no start accepted until the line returns to 1.
REQ-032 Two back-to-back frames 1100 then 0011 with no idle gap -> two valid pulses 6 cycles apart, parallel_out=1100 then 0011.
REQ-033 reset=1 asserted at the third data bit of a frame -> all outputs 0, no valid; a following full frame 1010 -> parallel_out=1010.
REQ-034 MSB_FIRST=0 with serial bits 0,1,1,0,0,1 -> parallel_out=4'b0011.
REQ-035 serial_in held at 1 for 100 cycles -> busy, valid and frame_err stay 0 and parallel_out is unchanged.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter/receiver pair.
// State encoding is fixed so both ends of the link decode it the same way.
package serial_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DATA      = 2'd1;
  localparam logic [1:0] ST_STOP      = 2'd2;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shifter; MSB_FIRST picks which end the first bit reaches.
// Assumes WIDTH >= 2.
module sipo_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      if (MSB_FIRST) q_d = {q_q[WIDTH-2:0], din};
      else           q_d = {din, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Receiver for start/data/stop frames sampled one bit per clk, no oversampling.
// States: IDLE (wait for start 0) | DATA (shift WIDTH bits) | STOP (check stop 1) | WAIT_IDLE (after bad stop, wait for line high)
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] shift_q;
  logic             shift_en;

  assign shift_en = (state_q == DATA);

  sipo_shift #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .shift_en(shift_en),
    .din     (serial_in),
    .q       (shift_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pout_d  = pout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) state_d = STOP;
      end
      STOP: begin
        if (serial_in) begin
          pout_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (serial_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Gating keeps strobes and busy low for the whole reset cycle, not just after the edge.
  assign parallel_out = pout_q;
  assign valid        = valid_q & ~reset;
  assign frame_err    = ferr_q & ~reset;
  assign busy         = ((state_q == DATA) || (state_q == STOP)) & ~reset;

endmodule
